udp_echo_app_stats_log: RTL and testbench
=========================================

# udp_echo_app_stats_log

Downstream consumer of the UDP echo app control path's statistics strobes. Accumulates the running total of echoed bytes, and on each log strobe records a {timestamp, byte-total} snapshot into a circular on-chip log. A valid/ready read port lets the stats readout logic fetch entries by index. Sits beside the echo app control, in the same tile, fed directly by its `app_stats_*` outputs.

## Interface
Parameters:
- `LOG_DEPTH`, 64: number of log entries; power of two, ≥2.
- `LOG_DEPTH_W`, `$clog2(LOG_DEPTH)`: index width.
- `TIMESTAMP_W`, 64: cycle-counter width.
- `BYTES_W`, 64: byte accumulator width; must be > `NOC_DATA_BYTES_W`+1.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `app_stats_do_log` in 1: snapshot strobe, one entry per asserted cycle.
- `app_stats_incr_bytes_sent` in 1: add `app_stats_num_bytes_sent` this cycle.
- `app_stats_num_bytes_sent` in `NOC_DATA_BYTES_W+1`: bytes in the current flit, 0..NOC_DATA_BYTES.
- `rd_req_val` in 1 / `rd_req_rdy` out 1: read request handshake.
- `rd_req_addr` in `LOG_DEPTH_W`: absolute entry index.
- `rd_resp_val` out 1 / `rd_resp_rdy` in 1: read response handshake.
- `rd_resp_entry_val` out 1: the addressed entry has been written since reset.
- `rd_resp_timestamp` out `TIMESTAMP_W`; `rd_resp_bytes` out `BYTES_W`: entry contents.
- `log_wr_ptr` out `LOG_DEPTH_W`: next index to be written.
- `log_wrapped` out 1: sticky; set once any entry has been overwritten.
- `bytes_total` out `BYTES_W`: live accumulator.

## Operation
- Timestamp: free-running counter. 0 after reset, +1 every cycle, wraps modulo 2^TIMESTAMP_W.
- Accumulator: on `incr`, `bytes_total += zero_extend(num_bytes_sent)`, modulo 2^BYTES_W. `num_bytes_sent` is ignored when `incr` is low.
- Log write on `do_log`:
  - Writes `mem[wr_ptr] = {timestamp_now, bytes_total_next}`. `bytes_total_next` includes any same-cycle increment.
  - Sets `written[wr_ptr]`.
  - `wr_ptr` advances by 1 and wraps at `LOG_DEPTH`.
  - If `written[wr_ptr]` was already set before this write, `log_wrapped` is set. It is cleared only by `rst`.
- A log write is never stalled; the oldest entry is overwritten.
- Read: a request is accepted when `rd_req_val && rd_req_rdy`. The response registers `mem[addr]` and `written[addr]` into a single output stage.
  - `rd_resp_val` stays asserted with stable data until `rd_resp_rdy`.
  - `rd_req_rdy = !rd_resp_val || rd_resp_rdy` (one-deep pipeline, full throughput).
- Unwritten entry: `rd_resp_entry_val` = 0, and timestamp and bytes read as 0.
- Same-cycle read and write to the same index: read-first. The response carries the pre-write contents and valid bit.
- Outputs are never X after reset.

## Timing
- Reset values:
  - `rd_resp_val`, `rd_resp_entry_val`, `rd_resp_timestamp`, `rd_resp_bytes`: 0.
  - `rd_req_rdy`: 1.
  - `log_wr_ptr`, `log_wrapped`, `bytes_total`: 0.
  - Timestamp counter and all `written` bits: 0.
  - `mem` contents need not be reset; the `written` bits mask them.
- `bytes_total` and `log_wr_ptr` update in the cycle after the strobe.
- Read latency: a request accepted in cycle N gives `rd_resp_val` high in cycle N+1.
- Back-to-back requests give one response per cycle while `rd_resp_rdy` is held high.
- `rst` asserted mid-transaction: the pending response is dropped and the log empties; the next cycle behaves as a fresh reset.
- There is no combinational path from `rd_resp_rdy` to the response data. The only combinational path is `rd_resp_rdy` → `rd_req_rdy`.

## Structure
- Shared package `udp_app_stats_pkg`:
  - `stats_log_entry_s` struct {timestamp, bytes}.
  - Default depth and width constants.
  - `NOC_DATA_BYTES_W` continues to come from the existing defs header.
- Natural sub-module: `stats_log_ram`, a 1R1W synchronous read-first RAM of `stats_log_entry_s`. It must be inferable as BRAM/LUTRAM.
- The `written` valid bits are kept in flops, outside the RAM.

## Test plan
- Reset, then wait 10 cycles with no strobes: read index 0 → `rd_resp_entry_val`=0, data 0, response 1 cycle after accept.
- Three `incr` strobes of 64, 64 and 17 bytes, then `do_log` one cycle later: `bytes_total`=145 and entry 0 has bytes=145 with the timestamp of the log cycle. `incr` of 32 together with `do_log` in the same cycle: logged bytes=177.
- Write `LOG_DEPTH`+3 entries: `log_wrapped`=1, `log_wr_ptr`=3, index 0 holds entry number `LOG_DEPTH` (0-based).
- Read index 5 while hold `rd_resp_rdy`=0 for 4 cycles: `rd_resp_val` and data remain stable and `rd_req_rdy`=0. Release: the next request is accepted in the same cycle.
- Read index k in the same cycle as `do_log` writes index k: the response shows the old contents, or `entry_val`=0 if k was never written. A second read shows the new contents.
- Assert `rst` while a response is pending and after 10 log entries: `rd_resp_val`=0 and all entries read `entry_val`=0.

Source files
------------

// File: rtl/udp_echo_app_stats_log_pkg.sv
// Shared types and default sizing for the UDP echo app statistics log.
// Entry layout is {timestamp, byte total} as captured on each log strobe.
package udp_app_stats_pkg;

  localparam int NOC_DATA_BYTES   = 64;
  localparam int NOC_DATA_BYTES_W = 6;

  localparam int LOG_DEPTH_DEF   = 64;
  localparam int TIMESTAMP_W_DEF = 64;
  localparam int BYTES_W_DEF     = 64;

  typedef struct packed {
    logic [TIMESTAMP_W_DEF-1:0] timestamp;
    logic [BYTES_W_DEF-1:0]     bytes;
  } stats_log_entry_s;

endpackage

// File: rtl/udp_echo_app_stats_log_if.sv
// Read port of the statistics log: request by index, registered response.
// master = readout logic, slave = the log.
interface udp_echo_app_stats_log_if #(
  parameter int LOG_DEPTH_W = 6,
  parameter int TIMESTAMP_W = 64,
  parameter int BYTES_W     = 64
);
  logic                   rd_req_val;
  logic                   rd_req_rdy;
  logic [LOG_DEPTH_W-1:0] rd_req_addr;
  logic                   rd_resp_val;
  logic                   rd_resp_rdy;
  logic                   rd_resp_entry_val;
  logic [TIMESTAMP_W-1:0] rd_resp_timestamp;
  logic [BYTES_W-1:0]     rd_resp_bytes;

  modport master (
    output rd_req_val, rd_req_addr, rd_resp_rdy,
    input  rd_req_rdy, rd_resp_val, rd_resp_entry_val,
    input  rd_resp_timestamp, rd_resp_bytes
  );

  modport slave (
    input  rd_req_val, rd_req_addr, rd_resp_rdy,
    output rd_req_rdy, rd_resp_val, rd_resp_entry_val,
    output rd_resp_timestamp, rd_resp_bytes
  );
endinterface

// File: rtl/udp_echo_app_stats_log_ram.sv
// 1R1W synchronous read-first RAM of log entries.
// No reset on storage or read register so it maps onto block/distributed RAM.
module stats_log_ram
  import udp_app_stats_pkg::*;
#(
  parameter int  DEPTH = LOG_DEPTH_DEF,
  parameter int  AW    = $clog2(DEPTH),
  parameter type T     = stats_log_entry_s
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  T              i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output T              o_rdata
);

  T r_mem [DEPTH];
  T r_rdata;

  // Read samples the old word when the same address is written this cycle.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/udp_echo_app_stats_log.sv
// Echoed-byte accumulator with a circular {timestamp, bytes} snapshot log
// and a one-deep valid/ready read port.
module udp_echo_app_stats_log
  import udp_app_stats_pkg::*;
#(
  parameter int LOG_DEPTH   = LOG_DEPTH_DEF,
  parameter int LOG_DEPTH_W = $clog2(LOG_DEPTH),
  parameter int TIMESTAMP_W = TIMESTAMP_W_DEF,
  parameter int BYTES_W     = BYTES_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      app_stats_do_log,
  input  logic                      app_stats_incr_bytes_sent,
  input  logic [NOC_DATA_BYTES_W:0] app_stats_num_bytes_sent,
  udp_echo_app_stats_log_if.slave   rd,
  output logic [LOG_DEPTH_W-1:0]    log_wr_ptr,
  output logic                      log_wrapped,
  output logic [BYTES_W-1:0]        bytes_total
);

  typedef struct packed {
    logic [TIMESTAMP_W-1:0] timestamp;
    logic [BYTES_W-1:0]     bytes;
  } entry_t;

  logic [TIMESTAMP_W-1:0] r_ts;
  logic [BYTES_W-1:0]     r_bytes;
  logic [BYTES_W-1:0]     w_bytes_next;
  logic [BYTES_W-1:0]     w_incr;
  logic [LOG_DEPTH_W-1:0] r_wr_ptr;
  logic [LOG_DEPTH-1:0]   r_written;
  logic                   r_wrapped;
  logic                   r_resp_val;
  logic                   r_entry_val;
  logic                   w_log;
  logic                   w_rd_accept;
  entry_t                 w_wdata;
  entry_t                 w_rdata;

  assign w_incr = app_stats_incr_bytes_sent ?
                  BYTES_W'(app_stats_num_bytes_sent) : '0;
  assign w_bytes_next = r_bytes + w_incr;
  assign w_log = app_stats_do_log && !rst;

  assign rd.rd_req_rdy = !r_resp_val || rd.rd_resp_rdy;
  assign w_rd_accept = rd.rd_req_val && rd.rd_req_rdy && !rst;

  assign w_wdata.timestamp = r_ts;
  assign w_wdata.bytes     = w_bytes_next;

  stats_log_ram #(
    .DEPTH (LOG_DEPTH),
    .AW    (LOG_DEPTH_W),
    .T     (entry_t)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_log),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_re    (w_rd_accept),
    .i_raddr (rd.rd_req_addr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts        <= '0;
      r_bytes     <= '0;
      r_wr_ptr    <= '0;
      r_written   <= '0;
      r_wrapped   <= 1'b0;
      r_resp_val  <= 1'b0;
      r_entry_val <= 1'b0;
    end else begin
      r_ts    <= r_ts + TIMESTAMP_W'(1);
      r_bytes <= w_bytes_next;
      if (app_stats_do_log) begin
        r_written[r_wr_ptr] <= 1'b1;
        r_wrapped <= r_wrapped | r_written[r_wr_ptr];
        r_wr_ptr  <= r_wr_ptr + LOG_DEPTH_W'(1);
      end
      // Valid bit sampled before this cycle's write: read-first.
      if (w_rd_accept) begin
        r_resp_val  <= 1'b1;
        r_entry_val <= r_written[rd.rd_req_addr];
      end else if (rd.rd_resp_rdy) begin
        r_resp_val <= 1'b0;
      end
    end
  end

  // Unwritten entries (and uninitialised RAM) read back as zero.
  assign rd.rd_resp_val       = r_resp_val;
  assign rd.rd_resp_entry_val = r_entry_val;
  assign rd.rd_resp_timestamp = r_entry_val ? w_rdata.timestamp : '0;
  assign rd.rd_resp_bytes     = r_entry_val ? w_rdata.bytes : '0;

  assign log_wr_ptr  = r_wr_ptr;
  assign log_wrapped = r_wrapped;
  assign bytes_total = r_bytes;

endmodule

// File: tb/tb_udp_echo_app_stats_log.sv
// Directed bench for the stats log: array-based reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_udp_echo_app_stats_log;
  import udp_app_stats_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TW    = 64;
  localparam int BW    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic do_log = 1'b0;
  logic incr = 1'b0;
  logic [NOC_DATA_BYTES_W:0] num = '0;
  logic [AW-1:0] wr_ptr;
  logic wrapped;
  logic [BW-1:0] total;

  int checks = 0;
  int errors = 0;

  udp_echo_app_stats_log_if #(
    .LOG_DEPTH_W (AW),
    .TIMESTAMP_W (TW),
    .BYTES_W     (BW)
  ) rif ();

  udp_echo_app_stats_log #(
    .LOG_DEPTH   (DEPTH),
    .LOG_DEPTH_W (AW),
    .TIMESTAMP_W (TW),
    .BYTES_W     (BW)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .app_stats_do_log          (do_log),
    .app_stats_incr_bytes_sent (incr),
    .app_stats_num_bytes_sent  (num),
    .rd                        (rif.slave),
    .log_wr_ptr                (wr_ptr),
    .log_wrapped               (wrapped),
    .bytes_total               (total)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  // Reference model: the log as plain arrays, updated once per clock.
  logic [63:0] m_ts_mem [DEPTH];
  logic [63:0] m_by_mem [DEPTH];
  bit          m_wr [DEPTH];
  int          m_ptr;
  bit          m_wrapped;
  logic [63:0] m_total;
  logic [63:0] m_ts;
  logic [63:0] m_nxt;
  bit          m_rv, m_rev, m_init = 0, m_acc;
  logic [63:0] m_rts, m_rby;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_ts = 0; m_total = 0; m_ptr = 0; m_wrapped = 0;
      m_rv = 0; m_rev = 0; m_rts = 0; m_rby = 0;
      for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
    end else if (m_init) begin
      m_acc = rif.rd_req_val && (!m_rv || rif.rd_resp_rdy);
      if (m_acc) begin
        m_rv  = 1;
        m_rev = m_wr[rif.rd_req_addr];
        m_rts = m_rev ? m_ts_mem[rif.rd_req_addr] : 64'd0;
        m_rby = m_rev ? m_by_mem[rif.rd_req_addr] : 64'd0;
      end else if (rif.rd_resp_rdy) begin
        m_rv = 0;
      end
      m_nxt = m_total + (incr ? 64'(num) : 64'd0);
      if (do_log) begin
        if (m_wr[m_ptr]) m_wrapped = 1;
        m_ts_mem[m_ptr] = m_ts;
        m_by_mem[m_ptr] = m_nxt;
        m_wr[m_ptr] = 1;
        m_ptr = (m_ptr + 1) % DEPTH;
      end
      m_total = m_nxt;
      m_ts = m_ts + 1;
    end
  end

  always @(posedge clk) begin
    #4;
    if (m_init) begin
      chk("bytes_total", total, m_total);
      chk("wr_ptr", 64'(wr_ptr), 64'(m_ptr));
      chk("wrapped", 64'(wrapped), 64'(m_wrapped));
      chk("req_rdy", 64'(rif.rd_req_rdy), 64'(!m_rv || rif.rd_resp_rdy));
      chk("resp_val", 64'(rif.rd_resp_val), 64'(m_rv));
      chk("resp_ev", 64'(rif.rd_resp_entry_val), 64'(m_rev));
      chk("resp_ts", rif.rd_resp_timestamp, m_rts);
      chk("resp_bytes", rif.rd_resp_bytes, m_rby);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; do_log = 0; incr = 0; num = '0;
    rif.rd_req_val = 0; rif.rd_resp_rdy = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input bit with_log,
                    output logic ev, output logic [63:0] ts,
                    output logic [63:0] by);
    rif.rd_req_val = 1; rif.rd_req_addr = a; rif.rd_resp_rdy = 1;
    do_log = with_log;
    tick();
    rif.rd_req_val = 0; do_log = 0;
    #1;
    chk("rd_latency", 64'(rif.rd_resp_val), 64'd1);
    ev = rif.rd_resp_entry_val;
    ts = rif.rd_resp_timestamp;
    by = rif.rd_resp_bytes;
    tick();
  endtask

  logic ev;
  logic [63:0] ts, by;

  initial begin
    rif.rd_req_val = 0; rif.rd_req_addr = '0; rif.rd_resp_rdy = 1;
    do_reset();
    chk("rst_total", total, 64'd0);
    chk("rst_ptr", 64'(wr_ptr), 64'd0);
    chk("rst_wrapped", 64'(wrapped), 64'd0);
    chk("rst_req_rdy", 64'(rif.rd_req_rdy), 64'd1);
    chk("rst_resp_val", 64'(rif.rd_resp_val), 64'd0);
    repeat (10) tick();
    rd(0, 0, ev, ts, by);
    chk("empty_ev", 64'(ev), 64'd0);
    chk("empty_ts", ts, 64'd0);
    chk("empty_by", by, 64'd0);

    // Three increments, then a log at timestamp 15.
    incr = 1; num = 7'd64; tick();
    num = 7'd64; tick();
    num = 7'd17; tick();
    incr = 0; do_log = 1; tick();
    do_log = 0;
    chk("total_145", total, 64'd145);
    rd(0, 0, ev, ts, by);
    chk("e0_ev", 64'(ev), 64'd1);
    chk("e0_by", by, 64'd145);
    chk("e0_ts", ts, 64'd15);
    incr = 1; num = 7'd32; do_log = 1; tick();
    incr = 0; do_log = 0;
    chk("total_177", total, 64'd177);
    rd(1, 0, ev, ts, by);
    chk("e1_by", by, 64'd177);
    chk("e1_ts", ts, 64'd18);

    // Wrap: DEPTH+3 logs, entry i carries bytes i+1.
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) begin
      do_log = 1; incr = 1; num = 7'd1; tick();
      if (i == DEPTH - 1) begin
        chk("nowrap_yet", 64'(wrapped), 64'd0);
        chk("ptr_wrap0", 64'(wr_ptr), 64'd0);
      end
      if (i == DEPTH) chk("wrap_first", 64'(wrapped), 64'd1);
    end
    do_log = 0; incr = 0;
    chk("wrap_ptr3", 64'(wr_ptr), 64'd3);
    chk("wrap_flag", 64'(wrapped), 64'd1);
    rd(0, 0, ev, ts, by);
    chk("wrap_idx0", by, 64'(DEPTH + 1));

    // Back-pressure on the response.
    rif.rd_req_val = 1; rif.rd_req_addr = 4'd5; rif.rd_resp_rdy = 0;
    tick();
    rif.rd_req_addr = 4'd6;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_val", 64'(rif.rd_resp_val), 64'd1);
      chk("stall_rdy", 64'(rif.rd_req_rdy), 64'd0);
      chk("stall_by", rif.rd_resp_bytes, 64'd6);
      tick();
    end
    rif.rd_resp_rdy = 1;
    #1;
    chk("release_rdy", 64'(rif.rd_req_rdy), 64'd1);
    tick();
    rif.rd_req_val = 0;
    #1;
    chk("next_val", 64'(rif.rd_resp_val), 64'd1);
    chk("next_by", rif.rd_resp_bytes, 64'd7);
    tick();

    // Same-cycle read and write of index 3.
    rd(3, 1, ev, ts, by);
    chk("rfirst_ev", 64'(ev), 64'd1);
    chk("rfirst_by", by, 64'd4);
    rd(3, 0, ev, ts, by);
    chk("rsecond_by", by, 64'(DEPTH + 3));

    // Same-cycle read and write of a never-written index.
    do_reset();
    incr = 1; num = 7'd5; tick();
    incr = 0;
    rd(0, 1, ev, ts, by);
    chk("nw_first_ev", 64'(ev), 64'd0);
    chk("nw_first_by", by, 64'd0);
    rd(0, 0, ev, ts, by);
    chk("nw_second_ev", 64'(ev), 64'd1);
    chk("nw_second_by", by, 64'd5);

    // Reset with a pending response and a partly filled log.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      do_log = 1; tick();
    end
    do_log = 0;
    rif.rd_req_val = 1; rif.rd_req_addr = 4'd2; rif.rd_resp_rdy = 0;
    tick();
    rif.rd_req_val = 0;
    #1;
    chk("pend_val", 64'(rif.rd_resp_val), 64'd1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_drop_val", 64'(rif.rd_resp_val), 64'd0);
    chk("rst_ptr_clr", 64'(wr_ptr), 64'd0);
    rif.rd_resp_rdy = 1;
    for (int i = 0; i < DEPTH; i++) begin
      rd(AW'(i), 0, ev, ts, by);
      chk("rst_ev", 64'(ev), 64'd0);
    end

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
